// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-stage state encoding and fault data.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    // Memory-stage access sequencer states
    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_DONE = 2'd2
    } mem_state_t;

    // Load data returned when an access is abandoned after a timeout
    localparam logic [15:0] MEM_FAULT_DATA = 16'hDEAD;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts consecutive enabled cycles and flags the last allowed one.
// Latency: expire is combinational in the TIMEOUT_CYCLES-th enabled cycle.
// Backpressure: none; the count saturates while enable stays high.
module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Expire fires during the final permitted cycle so the FSM leaves on that edge
    assign expire = enable && (count == LAST);

    // Count enabled cycles; clear restarts the window, saturate at the terminal value
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/memory_access_unit.sv
// CPU memory stage: load/store handshake with data memory, upstream stall, MEM/WB outputs.
// Latency: non-memory ops 0 cycles; memory ops stall 1 + WAIT cycles, result in MS_DONE.
// Backpressure: stall_out freezes upstream until mem_ack; MEM_TIMEOUT_EN adds an abort path.
module memory_access_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wbs_in,
    input  logic              mre_in,
    input  logic              mwe_in,
    input  logic [DATA_W-1:0] calcData_in,
    input  logic [DATA_W-1:0] storeData_in,
    input  logic              ni_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_out,
    output logic              wbs_out,
    output logic [DATA_W-1:0] memData_out,
    output logic [DATA_W-1:0] calcData_out,
    output logic              ni_out,
    output logic              fault_out
);

    // A zero-length timeout window would make every access fault immediately
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("memory_access_unit: TIMEOUT_CYCLES must be at least 1");
    end

    mem_state_t        state;
    mem_state_t        next_state;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] capture_data;
    logic              capture;
    logic              mem_op;
    logic              timeout_expire;
    logic              fault_set;

    // A valid instruction touching memory; a store wins if both enables are set
    assign mem_op = !ni_in && (mre_in || mwe_in);

    // Address and write data come straight from the frozen EX/MEM register
    assign mem_addr     = calcData_in;
    assign mem_wdata    = storeData_in;
    assign wbs_out      = wbs_in;
    assign calcData_out = calcData_in;
    assign mem_we       = mem_req && mwe_in;

    // Next-state and output decode; reset forces a quiet bubble regardless of state
    always_comb begin
        next_state   = state;
        mem_req      = 1'b0;
        stall_out    = 1'b0;
        ni_out       = ni_in;
        memData_out  = '0;
        capture      = 1'b0;
        capture_data = '0;
        fault_set    = 1'b0;

        case (state)
            MS_IDLE: begin
                if (mem_op) begin
                    mem_req    = 1'b1;
                    stall_out  = 1'b1;
                    ni_out     = 1'b1;
                    next_state = MS_WAIT;
                end
            end
            MS_WAIT: begin
                mem_req   = 1'b1;
                stall_out = 1'b1;
                ni_out    = 1'b1;
                if (mem_ack) begin
                    // Ack beats a coincident timeout; stores return zero
                    capture      = 1'b1;
                    capture_data = mwe_in ? '0 : mem_rdata;
                    next_state   = MS_DONE;
                end else if (timeout_expire) begin
                    capture      = 1'b1;
                    capture_data = DATA_W'(MEM_FAULT_DATA);
                    fault_set    = 1'b1;
                    next_state   = MS_DONE;
                end
            end
            MS_DONE: begin
                memData_out = rdata_q;
                next_state  = MS_IDLE;
            end
            default: begin
                next_state = MS_IDLE;
            end
        endcase

        if (rst) begin
            mem_req     = 1'b0;
            stall_out   = 1'b0;
            ni_out      = 1'b1;
            memData_out = '0;
        end
    end

    // State register; reset abandons any outstanding access
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MS_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Load data holding register, presented during MS_DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (capture) begin
            rdata_q <= capture_data;
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic fault_q;

    mem_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != MS_WAIT),
        .enable (state == MS_WAIT),
        .expire (timeout_expire)
    );

    // Sticky fault flag: only reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (fault_set) begin
            fault_q <= 1'b1;
        end
    end

    assign fault_out = fault_q;
`else
    // Without the timeout option MS_WAIT waits for the ack indefinitely
    assign timeout_expire = 1'b0;
    assign fault_out      = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed self-checking bench for memory_access_unit.
// Latency: checks 0-cycle pass-through and 1 + WAIT stall cycles per access.
// Backpressure: models memory ack timing directly; all waits are fixed-length.
module tb_memory_access_unit;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              wbs_in;
    logic              mre_in;
    logic              mwe_in;
    logic [DATA_W-1:0] calcData_in;
    logic [DATA_W-1:0] storeData_in;
    logic              ni_in;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              stall_out;
    logic              wbs_out;
    logic [DATA_W-1:0] memData_out;
    logic [DATA_W-1:0] calcData_out;
    logic              ni_out;
    logic              fault_out;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    memory_access_unit #(
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wbs_in       (wbs_in),
        .mre_in       (mre_in),
        .mwe_in       (mwe_in),
        .calcData_in  (calcData_in),
        .storeData_in (storeData_in),
        .ni_in        (ni_in),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .stall_out    (stall_out),
        .wbs_out      (wbs_out),
        .memData_out  (memData_out),
        .calcData_out (calcData_out),
        .ni_out       (ni_out),
        .fault_out    (fault_out)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Move to just after the next rising edge, where inputs are changed
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling
    task automatic settle();
        #2;
    endtask

    task automatic drive_bubble();
        ni_in        = 1'b1;
        mre_in       = 1'b0;
        mwe_in       = 1'b0;
        wbs_in       = 1'b0;
        calcData_in  = 16'h0000;
        storeData_in = 16'h0000;
        mem_ack      = 1'b0;
        mem_rdata    = 16'hAAAA;
    endtask

    // One complete access: IDLE issue cycle, wait_n empty WAIT cycles, ack cycle, DONE
    task automatic mem_access(input string tag, input logic mre, input logic mwe,
                              input logic [15:0] addr, input logic [15:0] wdata,
                              input int wait_n, input logic [15:0] rdata,
                              input logic [15:0] exp_data);
        int stalls;
        stalls = 0;
        tick();
        ni_in        = 1'b0;
        mre_in       = mre;
        mwe_in       = mwe;
        wbs_in       = 1'b1;
        calcData_in  = addr;
        storeData_in = wdata;
        mem_ack      = 1'b0;
        mem_rdata    = 16'hAAAA;
        settle();
        check({tag, " issue mem_req"}, 16'(mem_req), 16'd1);
        check({tag, " issue mem_we"}, 16'(mem_we), 16'(mwe));
        check({tag, " issue mem_addr"}, mem_addr, addr);
        check({tag, " issue ni_out"}, 16'(ni_out), 16'd1);
        if (mwe) check({tag, " issue mem_wdata"}, mem_wdata, wdata);
        if (stall_out) stalls++;
        for (int i = 0; i <= wait_n; i++) begin
            tick();
            mem_ack   = (i == wait_n);
            mem_rdata = (i == wait_n) ? rdata : 16'hAAAA;
            settle();
            check({tag, " wait mem_req"}, 16'(mem_req), 16'd1);
            check({tag, " wait ni_out"}, 16'(ni_out), 16'd1);
            if (stall_out) stalls++;
        end
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 16'h5555;
        settle();
        check({tag, " done memData_out"}, memData_out, exp_data);
        check({tag, " done ni_out"}, 16'(ni_out), 16'd0);
        check({tag, " done stall_out"}, 16'(stall_out), 16'd0);
        check({tag, " done mem_req"}, 16'(mem_req), 16'd0);
        check({tag, " done calcData_out"}, calcData_out, addr);
        check({tag, " stall cycles"}, 16'(stalls), 16'(wait_n + 2));
    endtask

    initial begin
        // Reset with a memory op presented: outputs must be forced quiet
        rst = 1'b1;
        drive_bubble();
        ni_in       = 1'b0;
        mre_in      = 1'b1;
        calcData_in = 16'h0040;
        settle();
        check("rst mem_req", 16'(mem_req), 16'd0);
        check("rst stall_out", 16'(stall_out), 16'd0);
        check("rst ni_out", 16'(ni_out), 16'd1);
        check("rst memData_out", memData_out, 16'h0000);
        tick();
        tick();
        rst = 1'b0;
        drive_bubble();
        settle();
        check("post-rst fault_out", 16'(fault_out), 16'd0);
        check("post-rst ni_out", 16'(ni_out), 16'd1);
        check("post-rst mem_req", 16'(mem_req), 16'd0);

        // Non-memory op passes straight through in the same cycle
        tick();
        ni_in       = 1'b0;
        calcData_in = 16'hABCD;
        wbs_in      = 1'b0;
        settle();
        check("alu calcData_out", calcData_out, 16'hABCD);
        check("alu ni_out", 16'(ni_out), 16'd0);
        check("alu stall_out", 16'(stall_out), 16'd0);
        check("alu mem_req", 16'(mem_req), 16'd0);
        check("alu wbs_out", 16'(wbs_out), 16'd0);
        check("alu memData_out", memData_out, 16'h0000);
        wbs_in = 1'b1;
        settle();
        check("alu wbs_out hi", 16'(wbs_out), 16'd1);

        // Load, ack on first WAIT cycle
        mem_access("load", 1'b1, 1'b0, 16'h0010, 16'h0000, 0, 16'h1234, 16'h1234);
        // Store with both enables: write wins, read data not captured
        mem_access("store", 1'b1, 1'b1, 16'h0020, 16'h5678, 0, 16'h9999, 16'h0000);
        // Slow memory: two extra wait cycles
        mem_access("slow", 1'b1, 1'b0, 16'h0030, 16'h0000, 2, 16'h0F0F, 16'h0F0F);
        // Back-to-back loads with no gap
        mem_access("b2b1", 1'b1, 1'b0, 16'h0040, 16'h0000, 0, 16'h1111, 16'h1111);
        mem_access("b2b2", 1'b1, 1'b0, 16'h0042, 16'h0000, 0, 16'h2222, 16'h2222);

        // Idle after DONE: bubble in, memData back to zero
        tick();
        drive_bubble();
        settle();
        check("after memData_out", memData_out, 16'h0000);
        check("after ni_out", 16'(ni_out), 16'd1);

        // Reset in MS_WAIT, then a late ack
        tick();
        ni_in       = 1'b0;
        mre_in      = 1'b1;
        calcData_in = 16'h0050;
        tick();
        settle();
        check("rstwait pre mem_req", 16'(mem_req), 16'd1);
        rst = 1'b1;
        settle();
        check("rstwait mem_req", 16'(mem_req), 16'd0);
        check("rstwait stall_out", 16'(stall_out), 16'd0);
        tick();
        rst = 1'b0;
        drive_bubble();
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        settle();
        check("late-ack mem_req", 16'(mem_req), 16'd0);
        check("late-ack stall_out", 16'(stall_out), 16'd0);
        check("late-ack memData_out", memData_out, 16'h0000);
        tick();
        mem_ack = 1'b0;
        settle();
        check("late-ack next memData_out", memData_out, 16'h0000);
        check("late-ack next mem_req", 16'(mem_req), 16'd0);

`ifdef MEM_TIMEOUT_EN
        // No ack: four WAIT cycles, then DONE with fault data
        tick();
        ni_in       = 1'b0;
        mre_in      = 1'b1;
        calcData_in = 16'h0060;
        settle();
        check("to issue stall_out", 16'(stall_out), 16'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            settle();
            check("to wait stall_out", 16'(stall_out), 16'd1);
            check("to wait fault_out", 16'(fault_out), 16'd0);
        end
        tick();
        settle();
        check("to done memData_out", memData_out, 16'hDEAD);
        check("to done fault_out", 16'(fault_out), 16'd1);
        check("to done stall_out", 16'(stall_out), 16'd0);
        tick();
        drive_bubble();
        tick();
        settle();
        check("to held fault_out", 16'(fault_out), 16'd1);
        // Ack in the expiry cycle is a normal completion; fault stays sticky
        mem_access("to-ack", 1'b1, 1'b0, 16'h0070, 16'h0000, 3, 16'h4321, 16'h4321);
        check("to-ack fault_out", 16'(fault_out), 16'd1);
        tick();
        drive_bubble();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("to cleared fault_out", 16'(fault_out), 16'd0);
`else
        check("no-timeout fault_out", 16'(fault_out), 16'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Memory stage of the 16-bit pipelined CPU; sits between the ExecuteMemory register and the MemoryWriteback register. It performs load/store handshakes with the data memory, stalls the upstream pipeline while an access is outstanding, and produces `wbs`, `memData`, `calcData` and `ni` for the MemoryWriteback register. Non-memory instructions pass straight through with no added latency.

## Interface
- `DATA_W`, 16: data and address width.
- `TIMEOUT_CYCLES`, 16: number of WAIT cycles before an access is aborted. Used only with `MEM_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wbs_in`  in  1  writeback select from ExecuteMemory.
- `mre_in`  in  1  memory read enable.
- `mwe_in`  in  1  memory write enable.
- `calcData_in`  in  DATA_W  ALU result; also the memory address.
- `storeData_in`  in  DATA_W  store data.
- `ni_in`  in  1  no-instruction (bubble) flag.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write strobe; qualified by `mem_req`.
- `mem_addr`  out  DATA_W  equals `calcData_in`.
- `mem_wdata`  out  DATA_W  equals `storeData_in`.
- `mem_rdata`  in  DATA_W  read data; valid while `mem_ack` is high.
- `mem_ack`  in  1  one-cycle completion pulse.
- `stall_out`  out  1  freezes PC, IF/ID, ID/EX and EX/MEM registers.
- `wbs_out`, `memData_out` (DATA_W), `calcData_out` (DATA_W), `ni_out`  out: to the MemoryWriteback register.
- `fault_out`  out  1  sticky access-timeout flag.

## Operation
- A memory op is `ni_in==0 && (mre_in || mwe_in)`. If both enables are high, `mwe_in` wins: a store is performed and no read occurs.
- FSM states:
  - MS_IDLE:
    - With no memory op: pass-through. `ni_out=ni_in`, `memData_out=0`, `stall_out=0`, `mem_req=0`.
    - With a memory op: `mem_req=1`, `mem_we=mwe_in`, `stall_out=1`, `ni_out=1`; transition to MS_WAIT.
  - MS_WAIT:
    - `mem_req=1`, `stall_out=1`, `ni_out=1`.
    - On `mem_ack`: capture `mem_rdata` into `rdata_q` for loads, or 0 for stores; transition to MS_DONE.
  - MS_DONE:
    - `mem_req=0`, `stall_out=0`, `ni_out=ni_in` (0), `memData_out=rdata_q`; transition to MS_IDLE.
- `wbs_out=wbs_in` and `calcData_out=calcData_in` in every state. The inputs stay stable during a stall because the upstream registers are frozen.
- `mem_ack` is ignored outside MS_WAIT.
- While `rst==1`, outputs are forced: `mem_req=0`, `stall_out=0`, `ni_out=1`, `memData_out=0`. After the reset edge: MS_IDLE, `rdata_q=0`, counter=0, `fault_out=0`.
- Reset mid-access abandons the transaction. `mem_req` is low from that cycle on, and a late `mem_ack` is ignored.

## Timing
- Non-memory instruction: 0 added cycles (combinational path to the MemoryWriteback register).
- Memory op with ack on the first WAIT cycle: `stall_out` high for 2 cycles. The result is presented in cycle 3 (MS_DONE). Each additional wait cycle adds 1.
- Bubbles (`ni_out=1`) are inserted for every stalled cycle.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter runs in MS_WAIT.
  - After `TIMEOUT_CYCLES` cycles without `mem_ack`, the unit goes to MS_DONE with `rdata_q=16'hDEAD` and `fault_out` set.
  - `fault_out` stays set until `rst`.
  - An ack in the same cycle the count expires takes priority as a normal completion.
- `MEM_TIMEOUT_EN` undefined:
  - MS_WAIT waits indefinitely.
  - `fault_out` is tied to 0.
  - The counter is not instantiated.

## Structure
- Shared package `cpu_pkg`:
  - `mem_state_t` enum: MS_IDLE, MS_WAIT, MS_DONE.
  - `MEM_FAULT_DATA = 16'hDEAD`.
- Sub-module `mem_timeout_counter`: clear/enable/expire, parameterised by `TIMEOUT_CYCLES`. Instantiated only under `MEM_TIMEOUT_EN`.

## Test plan
- Non-memory op (`ni_in=0`, `mre_in=mwe_in=0`, `calcData_in=16'hABCD`, `wbs_in=0`) -> same cycle: `calcData_out=ABCD`, `ni_out=0`, `stall_out=0`, `mem_req=0`.
- Load at `16'h0010`, memory acks after 1 WAIT cycle with `16'h1234` -> `stall_out` high for 2 cycles with `ni_out=1`; in MS_DONE, `memData_out=1234` and `ni_out=0`.
- Store `16'h5678` to `16'h0020`, both enables high -> `mem_we=1`, `mem_wdata=5678`, `mem_addr=0020`; MS_DONE gives `memData_out=0`.
- `rst` asserted in MS_WAIT, then `mem_ack` one cycle later -> `mem_req=0` after the edge; the ack is ignored; `memData_out=0`, `stall_out=0`.
- `MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES=4`, no ack -> after 4 WAIT cycles, `memData_out=DEAD` and `fault_out=1`, held until `rst`.
- Back-to-back loads (`16'h1111` then `16'h2222`, ack on the first WAIT cycle each) -> two separate 3-cycle sequences with correct data and no lost instruction.
